// File: rtl/uart_rx_frame_receiver.sv
// UART receive frame recovery: 2-flop line synchroniser, oversampled 3-point
// majority vote per bit, start/data/parity/stop FSM with registered result pulses.
module uart_rx_frame_receiver #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 8,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int BIT_CNT_W = $clog2(DATA_WIDTH + 1);

    localparam logic [CNT_WIDTH-1:0] SAMP_LO  = CNT_WIDTH'(PRESCALE / 2 - 1);
    localparam logic [CNT_WIDTH-1:0] SAMP_MID = CNT_WIDTH'(PRESCALE / 2);
    localparam logic [CNT_WIDTH-1:0] SAMP_HI  = CNT_WIDTH'(PRESCALE / 2 + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(PRESCALE - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Expected parity bit is XOR of data (even) or its inverse (odd).
    function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] data,
                                             input logic rx_bit, input logic odd);
        return (^data) ^ rx_bit ^ odd;
    endfunction

    state_t                  state_q, state_d;
    logic                    rx_meta_q, rx_s_q;
    logic [CNT_WIDTH-1:0]    edge_cnt_q, edge_cnt_d;
    logic [BIT_CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [1:0]              samp_q, samp_d;
    logic                    bit_q, bit_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    par_en_q, par_en_d;
    logic                    par_type_q, par_type_d;
    logic                    par_err_q, par_err_d;
    logic                    wait_high_q, wait_high_d;
    logic [DATA_WIDTH-1:0]   p_data_q, p_data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    parity_error_q, parity_error_d;
    logic                    stop_error_q, stop_error_d;
    logic                    busy_q, busy_d;
    logic                    vote_s, sample_now_s, bit_end_s;

    assign vote_s       = majority3(samp_q[0], samp_q[1], rx_s_q);
    assign sample_now_s = (edge_cnt_q == SAMP_HI);
    assign bit_end_s    = (edge_cnt_q == CNT_LAST);

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_s_q    <= rx_meta_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            edge_cnt_q     <= '0;
            bit_cnt_q      <= '0;
            samp_q         <= 2'b11;
            bit_q          <= 1'b1;
            shift_q        <= '0;
            par_en_q       <= 1'b0;
            par_type_q     <= 1'b0;
            par_err_q      <= 1'b0;
            wait_high_q    <= 1'b0;
            p_data_q       <= '0;
            data_valid_q   <= 1'b0;
            parity_error_q <= 1'b0;
            stop_error_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            edge_cnt_q     <= edge_cnt_d;
            bit_cnt_q      <= bit_cnt_d;
            samp_q         <= samp_d;
            bit_q          <= bit_d;
            shift_q        <= shift_d;
            par_en_q       <= par_en_d;
            par_type_q     <= par_type_d;
            par_err_q      <= par_err_d;
            wait_high_q    <= wait_high_d;
            p_data_q       <= p_data_d;
            data_valid_q   <= data_valid_d;
            parity_error_q <= parity_error_d;
            stop_error_q   <= stop_error_d;
            busy_q         <= busy_d;
        end
    end

    // Next-state, sampling and result-pulse logic.
    always_comb begin
        state_d        = state_q;
        edge_cnt_d     = bit_end_s ? '0 : edge_cnt_q + CNT_WIDTH'(1);
        bit_cnt_d      = bit_cnt_q;
        samp_d         = samp_q;
        bit_d          = bit_q;
        shift_d        = shift_q;
        par_en_d       = par_en_q;
        par_type_d     = par_type_q;
        par_err_d      = par_err_q;
        wait_high_d    = wait_high_q;
        p_data_d       = p_data_q;
        data_valid_d   = 1'b0;
        parity_error_d = 1'b0;
        stop_error_d   = 1'b0;

        if (edge_cnt_q == SAMP_LO) begin
            samp_d[0] = rx_s_q;
        end else if (edge_cnt_q == SAMP_MID) begin
            samp_d[1] = rx_s_q;
        end else begin
            samp_d = samp_q;
        end

        if (state_q != ST_IDLE && sample_now_s) begin
            bit_d = vote_s;
        end else begin
            bit_d = bit_q;
        end

        case (state_q)
            ST_IDLE: begin
                edge_cnt_d = '0;
                if (wait_high_q) begin
                    // After a break, re-arm only once the line has returned high.
                    wait_high_d = !rx_s_q;
                end else if (!rx_s_q) begin
                    state_d    = ST_START;
                    edge_cnt_d = CNT_WIDTH'(1);
                    bit_cnt_d  = '0;
                    par_en_d   = parity_enable;
                    par_type_d = parity_type;
                    par_err_d  = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (sample_now_s && vote_s) begin
                    state_d    = ST_IDLE;
                    edge_cnt_d = '0;
                end else if (bit_end_s) begin
                    state_d = ST_DATA;
                end else begin
                    state_d = ST_START;
                end
            end
            ST_DATA: begin
                if (sample_now_s) begin
                    shift_d = {vote_s, shift_q[DATA_WIDTH-1:1]};
                end else begin
                    shift_d = shift_q;
                end
                if (bit_end_s) begin
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q;
                end
            end
            ST_PARITY: begin
                if (sample_now_s) begin
                    par_err_d = parity_mismatch(shift_q, vote_s, par_type_q);
                end else begin
                    par_err_d = par_err_q;
                end
                if (bit_end_s) begin
                    state_d = ST_STOP;
                end else begin
                    state_d = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    state_d = ST_IDLE;
                    if (!bit_q) begin
                        stop_error_d = 1'b1;
                        wait_high_d  = 1'b1;
                    end else if (par_err_q) begin
                        parity_error_d = 1'b1;
                    end else begin
                        p_data_d     = shift_q;
                        data_valid_d = 1'b1;
                    end
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                edge_cnt_d = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    assign p_data       = p_data_q;
    assign data_valid   = data_valid_q;
    assign parity_error = parity_error_q;
    assign stop_error   = stop_error_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Directed bench for uart_rx_frame_receiver: serial frames driven bit by bit,
// result pulses collected by a negedge monitor and checked per scenario.
module tb_uart_rx_frame_receiver;

    localparam int W = 8;
    localparam int P = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rx_in;
    logic         parity_enable;
    logic         parity_type;
    logic [W-1:0] p_data;
    logic         data_valid;
    logic         parity_error;
    logic         stop_error;
    logic         busy;

    int tests = 0;
    int fails = 0;

    int           cyc = 0;
    int           dv_cnt = 0;
    int           pe_cnt = 0;
    int           se_cnt = 0;
    int           busy_rises = 0;
    int           busy_rise_cyc = 0;
    int           dv_cyc = 0;
    logic         busy_prev = 1'b0;
    logic [W-1:0] dv_log[$];

    uart_rx_frame_receiver #(.DATA_WIDTH(W), .PRESCALE(P), .CNT_WIDTH(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_in        (rx_in),
        .parity_enable(parity_enable),
        .parity_type  (parity_type),
        .p_data       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Pulse collector, sampled away from the active edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (data_valid === 1'b1) begin
            dv_cnt = dv_cnt + 1;
            dv_cyc = cyc;
            dv_log.push_back(p_data);
        end
        if (parity_error === 1'b1) pe_cnt = pe_cnt + 1;
        if (stop_error === 1'b1) se_cnt = se_cnt + 1;
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            busy_rises    = busy_rises + 1;
            busy_rise_cyc = cyc;
        end
        busy_prev = busy;
    end

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (P) @(negedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic with_par,
                              input logic pbit, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < W; i++) drive_bit(d[i]);
        if (with_par) drive_bit(pbit);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        rx_in = 1'b1;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        repeat (3) @(negedge clk);
        tests++; if (p_data !== 8'h00) begin fails++; $display("FAIL reset_p_data got %h exp 00", p_data); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_dv got %b exp 0", data_valid); end
        tests++; if (parity_error !== 1'b0) begin fails++; $display("FAIL reset_pe got %b exp 0", parity_error); end
        tests++; if (stop_error !== 1'b0) begin fails++; $display("FAIL reset_se got %b exp 0", stop_error); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", busy); end
        rst_n = 1'b1;
        idle(10);
    endtask

    task automatic test_even_parity;
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        parity_enable = 1'b1;
        parity_type = 1'b0;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(12);
        tests++; if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL even_dv_cycles got %0d exp 1", dv_cnt - dv0); end
        tests++; if (p_data !== 8'hA5) begin fails++; $display("FAIL even_p_data got %h exp a5", p_data); end
        tests++; if (pe_cnt - pe0 !== 0) begin fails++; $display("FAIL even_pe got %0d exp 0", pe_cnt - pe0); end
        tests++; if (se_cnt - se0 !== 0) begin fails++; $display("FAIL even_se got %0d exp 0", se_cnt - se0); end
        tests++; if (dv_cyc - busy_rise_cyc !== 8 * 11 - 1) begin
            fails++; $display("FAIL even_latency got %0d exp %0d", dv_cyc - busy_rise_cyc, 8 * 11 - 1);
        end
    endtask

    task automatic test_odd_parity;
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        parity_enable = 1'b1;
        parity_type = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1);
        idle(12);
        tests++; if (pe_cnt - pe0 !== 1) begin fails++; $display("FAIL odd_pe got %0d exp 1", pe_cnt - pe0); end
        tests++; if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL odd_dv got %0d exp 0", dv_cnt - dv0); end
        tests++; if (se_cnt - se0 !== 0) begin fails++; $display("FAIL odd_se got %0d exp 0", se_cnt - se0); end
        tests++; if (p_data !== 8'hA5) begin fails++; $display("FAIL odd_p_data got %h exp a5", p_data); end
    endtask

    task automatic test_stop_error;
        int dv0, pe0, se0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(12);
        tests++; if (se_cnt - se0 !== 1) begin fails++; $display("FAIL stop_se got %0d exp 1", se_cnt - se0); end
        tests++; if (pe_cnt - pe0 !== 0) begin fails++; $display("FAIL stop_pe got %0d exp 0", pe_cnt - pe0); end
        tests++; if (dv_cnt - dv0 !== 0) begin fails++; $display("FAIL stop_dv got %0d exp 0", dv_cnt - dv0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL stop_busy got %b exp 0", busy); end
        tests++; if (p_data !== 8'hA5) begin fails++; $display("FAIL stop_p_data got %h exp a5", p_data); end
        dv0 = dv_cnt;
        send_frame(8'h81, 1'b0, 1'b0, 1'b1);
        idle(12);
        tests++; if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL after_stop_dv got %0d exp 1", dv_cnt - dv0); end
        tests++; if (p_data !== 8'h81) begin fails++; $display("FAIL after_stop_p_data got %h exp 81", p_data); end
    endtask

    task automatic test_glitch;
        int dv0, pe0, se0, br0;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt; br0 = busy_rises;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        idle(16);
        tests++; if (busy_rises - br0 !== 1) begin fails++; $display("FAIL glitch_busy_seen got %0d exp 1", busy_rises - br0); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL glitch_busy got %b exp 0", busy); end
        tests++; if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            fails++; $display("FAIL glitch_pulses got %0d exp 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        dv0 = dv_cnt;
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        idle(12);
        tests++; if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL glitch_next_dv got %0d exp 1", dv_cnt - dv0); end
        tests++; if (p_data !== 8'h55) begin fails++; $display("FAIL glitch_next_p_data got %h exp 55", p_data); end
    endtask

    task automatic test_back_to_back;
        int dv0, q0, pe0, se0;
        logic [W-1:0] exp_v [3];
        exp_v[0] = 8'h00; exp_v[1] = 8'hFF; exp_v[2] = 8'h5A;
        dv0 = dv_cnt; q0 = dv_log.size(); pe0 = pe_cnt; se0 = se_cnt;
        parity_enable = 1'b0;
        for (int f = 0; f < 3; f++) send_frame(exp_v[f], 1'b0, 1'b0, 1'b1);
        idle(12);
        tests++; if (dv_cnt - dv0 !== 3) begin fails++; $display("FAIL b2b_dv_count got %0d exp 3", dv_cnt - dv0); end
        tests++; if (pe_cnt - pe0 + se_cnt - se0 !== 0) begin fails++; $display("FAIL b2b_errors got %0d exp 0", pe_cnt - pe0 + se_cnt - se0); end
        for (int f = 0; f < 3; f++) begin
            tests++;
            if (q0 + f >= dv_log.size()) begin
                fails++; $display("FAIL b2b_value%0d got none exp %h", f, exp_v[f]);
            end else if (dv_log[q0 + f] !== exp_v[f]) begin
                fails++; $display("FAIL b2b_value%0d got %h exp %h", f, dv_log[q0 + f], exp_v[f]);
            end
        end
    endtask

    task automatic test_reset_mid_frame;
        int dv0, pe0, se0;
        logic [W-1:0] d;
        d = 8'hC3;
        dv0 = dv_cnt; pe0 = pe_cnt; se0 = se_cnt;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        rx_in = d[4];
        repeat (P / 2) @(negedge clk);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL midrst_busy_before got %b exp 1", busy); end
        rst_n = 1'b0;
        #1;
        tests++; if (p_data !== 8'h00) begin fails++; $display("FAIL midrst_p_data got %h exp 00", p_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL midrst_busy got %b exp 0", busy); end
        tests++; if ({data_valid, parity_error, stop_error} !== 3'b000) begin
            fails++; $display("FAIL midrst_pulses got %b exp 000", {data_valid, parity_error, stop_error});
        end
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(16);
        tests++; if ((dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0) !== 0) begin
            fails++; $display("FAIL midrst_no_pulse got %0d exp 0", (dv_cnt - dv0) + (pe_cnt - pe0) + (se_cnt - se0));
        end
        send_frame(8'hC3, 1'b0, 1'b0, 1'b1);
        idle(12);
        tests++; if (dv_cnt - dv0 !== 1) begin fails++; $display("FAIL midrst_next_dv got %0d exp 1", dv_cnt - dv0); end
        tests++; if (p_data !== 8'hC3) begin fails++; $display("FAIL midrst_next_p_data got %h exp c3", p_data); end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_stop_error();
        test_glitch();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
